// File: rtl/inst_encode_loader.sv
// -----------------------------------------------------------------------------
// inst_encode_loader
//
// Write-side counterpart of the instruction decoder. Field sets arrive over a
// valid/ready handshake, are packed into 32-bit instruction words, buffered in a
// small FIFO and written to instruction memory at consecutive word addresses
// starting from a programmed base address.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where the producer's valid and the consumer's ready are both 1. The producer
// holds its payload stable while valid=1 and ready=0. in_ready depends only on
// registered state (no combinational path from in_valid).
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           begin a load session (sampled only in IDLE)
//   base_addr       first write byte address, bits [1:0] forced to 0
//   in_valid/ready  field-set handshake
//   in_class..imm   instruction fields
//   in_last         final instruction of the session
//   imem_wr_en      write request (FIFO non-empty while running)
//   imem_wr_ready   memory accepts the write this cycle
//   imem_addr       write byte address
//   imem_wr_data    encoded word (FIFO head)
//   busy            session in progress (state != IDLE)
//   done            one-cycle pulse when the session completes
//   err_illegal     sticky flag: an unsupported class was received
//   inst_count      words written this session
//   dbg_state       FSM state for observation
// -----------------------------------------------------------------------------
module inst_encode_loader #(
  parameter int INST_BIT_WIDTH = 32,
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_BIT_WIDTH-1:0] base_addr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_class,
  input  logic [3:0]                in_fn,
  input  logic [3:0]                in_rd,
  input  logic [3:0]                in_rs1,
  input  logic [3:0]                in_rs2,
  input  logic [15:0]               in_imm,
  input  logic                      in_last,
  output logic                      imem_wr_en,
  input  logic                      imem_wr_ready,
  output logic [ADDR_BIT_WIDTH-1:0] imem_addr,
  output logic [INST_BIT_WIDTH-1:0] imem_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err_illegal,
  output logic [15:0]               inst_count,
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Primary opcode classes understood by the decoder.
  localparam logic [3:0] C_ALU  = 4'b0000;
  localparam logic [3:0] C_CMP  = 4'b0010;
  localparam logic [3:0] C_SW   = 4'b0101;
  localparam logic [3:0] C_BR   = 4'b0110;
  localparam logic [3:0] C_ALUI = 4'b1000;
  localparam logic [3:0] C_LW   = 4'b1001;
  localparam logic [3:0] C_CMPI = 4'b1010;
  localparam logic [3:0] C_JAL  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Session registers
  logic [ADDR_BIT_WIDTH-1:0] addr_q;
  logic [15:0]               count_q;
  logic                      err_q;
  logic                      last_seen;

  // FIFO storage and bookkeeping
  logic [INST_BIT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_count;
  logic [CNT_W-1:0]          fifo_count_next;
  logic                      fifo_full;
  logic                      fifo_empty;

  // Encoder
  logic [INST_BIT_WIDTH-1:0] enc_word;
  logic                      enc_legal;

  // Handshake events
  logic accept;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Field packing. Unused fields of each format are dropped and the remaining
  // bits are zero, matching what the decoder expects for each class.
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_class)
      C_ALU, C_CMP:   enc_word = {in_class, in_fn, in_rd, in_rs1, in_rs2, 12'h000};
      C_ALUI, C_CMPI: enc_word = {in_class, in_fn, in_rd, in_rs1, in_imm};
      C_BR:           enc_word = {in_class, in_fn, in_rs1, in_rs2, in_imm};
      C_LW, C_JAL:    enc_word = {in_class, 4'h0, in_rd, in_rs1, in_imm};
      C_SW:           enc_word = {in_class, 4'h0, in_rs1, in_rs2, in_imm};
      default:        enc_legal = 1'b0;
    endcase
  end

  // Fullness comes from the registered count only: a pop in the same cycle
  // does not make room for that cycle's push.
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  assign accept = in_valid && in_ready;
  // Illegal classes are consumed from the input side but never buffered.
  assign push   = accept && enc_legal;
  assign pop    = imem_wr_en && imem_wr_ready;

  always_comb begin
    fifo_count_next = fifo_count;
    if (push && !pop) begin
      fifo_count_next = fifo_count + CNT_W'(1);
    end else if (pop && !push) begin
      fifo_count_next = fifo_count - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // The session ends once the last field set has been taken (this cycle or
  // earlier) and the buffer will be empty after this cycle's push/pop. This
  // also lets an illegal final instruction with nothing buffered reach DONE
  // on the very next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if ((last_seen || (accept && in_last)) && (fifo_count_next == '0)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    imem_wr_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RUN: begin
        in_ready   = !fifo_full && !last_seen;
        imem_wr_en = !fifo_empty;
        busy       = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Session registers: write address, word counter, sticky error, last flag.
  // Address and counter keep their values after the session until next start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (start) begin
          addr_q    <= {base_addr[ADDR_BIT_WIDTH-1:2], 2'b00};
          count_q   <= '0;
          err_q     <= 1'b0;
          last_seen <= 1'b0;
        end
      end else if (state == S_RUN) begin
        if (accept && in_last) begin
          last_seen <= 1'b1;
        end
        if (accept && !enc_legal) begin
          err_q <= 1'b1;
        end
        if (pop) begin
          // Both wrap naturally at their register widths.
          addr_q  <= addr_q + ADDR_BIT_WIDTH'(4);
          count_q <= count_q + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO. Storage is cleared on reset so the head (and therefore imem_wr_data)
  // reads zero after reset. Pointers wrap because the depth is a power of two.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= enc_word;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count_next;
    end
  end

  // The head only moves on a pop, so data and address stay put while a write
  // is stalled by imem_wr_ready=0.
  assign imem_wr_data = fifo_mem[rd_ptr];
  assign imem_addr    = addr_q;
  assign inst_count   = count_q;
  assign err_illegal  = err_q;

endmodule

// File: tb/tb_inst_encode_loader.sv
// -----------------------------------------------------------------------------
// Testbench for inst_encode_loader: table of known encodings, directed
// multi-cycle sequences and randomized sessions checked against a reference
// model of the instruction formats and the memory write sequence.
// -----------------------------------------------------------------------------
module tb_inst_encode_loader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class, in_fn, in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic        in_last;
  logic        imem_wr_en;
  logic        imem_wr_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wr_data;
  logic        busy, done, err_illegal;
  logic [15:0] inst_count;
  logic [1:0]  dbg_state;

  inst_encode_loader #(
    .INST_BIT_WIDTH(32),
    .ADDR_BIT_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_fn(in_fn), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_wr_en(imem_wr_en), .imem_wr_ready(imem_wr_ready),
    .imem_addr(imem_addr), .imem_wr_data(imem_wr_data),
    .busy(busy), .done(done), .err_illegal(err_illegal),
    .inst_count(inst_count), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];   // {addr, data} expected writes
  logic [63:0] obs_q[$];   // {addr, data} observed writes
  logic [31:0] model_addr;
  int          model_words;
  logic        model_err;
  logic        rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference encoding: each class selects which three nibble fields follow
  // the class nibble and what fills the low half-word.
  function automatic logic [32:0] ref_encode(input logic [3:0] cls, fn, rd, rs1, rs2,
                                             input logic [15:0] imm);
    logic [31:0] a, b, c, low;
    logic legal;
    legal = 1'b1;
    a = 0; b = 0; c = 0; low = 0;
    case (int'(cls))
      0, 2:   begin a = fn; b = rd;  c = rs1; low = rs2 * 4096; end
      8, 10:  begin a = fn; b = rd;  c = rs1; low = imm; end
      6:      begin a = fn; b = rs1; c = rs2; low = imm; end
      9, 11:  begin a = 0;  b = rd;  c = rs1; low = imm; end
      5:      begin a = 0;  b = rs1; c = rs2; low = imm; end
      default: legal = 1'b0;
    endcase
    return {legal, (32'(cls) << 28) + (a << 24) + (b << 20) + (c << 16) + low};
  endfunction

  function automatic void model_accept(input logic [3:0] cls, fn, rd, rs1, rs2,
                                       input logic [15:0] imm);
    logic [32:0] r;
    r = ref_encode(cls, fn, rd, rs1, rs2, imm);
    if (r[32]) begin
      exp_q.push_back({model_addr, r[31:0]});
      model_addr  = model_addr + 32'd4;
      model_words++;
    end else begin
      model_err = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Write monitor: samples on the falling edge; a request seen here completes
  // at the next rising edge. Also checks hold stability during stalls.
  // ---------------------------------------------------------------------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_wr_en_held", imem_wr_en, 1'b1);
          check("stall_addr_held", imem_addr, prev_addr);
          check("stall_data_held", imem_wr_data, prev_data);
        end
        if (imem_wr_en && imem_wr_ready) obs_q.push_back({imem_addr, imem_wr_data});
        prev_stall = imem_wr_en && !imem_wr_ready;
        prev_addr  = imem_addr;
        prev_data  = imem_wr_data;
      end
    end
  end

  // Random memory back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) imem_wr_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic do_start(input logic [31:0] base);
    exp_q.delete();
    obs_q.delete();
    model_addr  = {base[31:2], 2'b00};
    model_words = 0;
    model_err   = 1'b0;
    base_addr   = base;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] cls, fn, rd, rs1, rs2,
                           input logic [15:0] imm, input logic last);
    logic ok;
    ok = 1'b0;
    in_class = cls; in_fn = fn; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) model_accept(cls, fn, rd, rs1, rs2, imm);
    else check("send_accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_cleared", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_session(input string tag);
    check({tag, "_write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_write"}, obs_q[i], exp_q[i]);
    end
    check({tag, "_inst_count"}, inst_count, 16'(model_words));
    check({tag, "_err_illegal"}, err_illegal, model_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_wr_en"}, imem_wr_en, 1'b0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_data"}, imem_wr_data, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err_illegal, 1'b0);
    check({tag, "_count"}, inst_count, 16'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Known-encoding table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  cls, fn, rd, rs1, rs2;
    logic [15:0] imm;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  // Global time limit
  initial begin
    #600000;
    n_errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0] = '{4'h0, 4'h7, 4'h3, 4'h1, 4'h2, 16'h0000, 32'h07312000}; // ALU
    vecs[1] = '{4'h8, 4'h0, 4'h5, 4'h0, 4'h9, 16'h1234, 32'h80501234}; // ALUI
    vecs[2] = '{4'h6, 4'h1, 4'h9, 4'h4, 4'h6, 16'hFFFF, 32'h6146FFFF}; // BR
    vecs[3] = '{4'h5, 4'h3, 4'h1, 4'h2, 4'h7, 16'h0008, 32'h50270008}; // SW
    vecs[4] = '{4'h2, 4'hA, 4'hB, 4'hC, 4'hD, 16'hFFFF, 32'h2ABCD000}; // CMP
    vecs[5] = '{4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 16'hBEEF, 32'hA123BEEF}; // CMPI
    vecs[6] = '{4'h9, 4'hF, 4'h4, 4'h5, 4'h6, 16'h0010, 32'h90450010}; // LW
    vecs[7] = '{4'hB, 4'h7, 4'h1, 4'hE, 4'h3, 16'hCAFE, 32'hB01ECAFE}; // JAL

    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_class = '0; in_fn = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_last = 1'b0; imem_wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // --- table: one-word sessions with known encodings
    imem_wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_start(32'h100 + 32'(i * 16));
      send_word(vecs[i].cls, vecs[i].fn, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                vecs[i].imm, 1'b1);
      wait_done();
      compare_session("table");
      if (obs_q.size() > 0) begin
        check("table_word", obs_q[0][31:0], vecs[i].exp_word);
        check("table_addr", obs_q[0][63:32], 32'h100 + 32'(i * 16));
      end else begin
        check("table_no_write", 64'(obs_q.size()), 64'd1);
      end
      check("table_inst_count_one", inst_count, 16'd1);
    end

    // --- three-word session, unaligned base gets its low bits cleared
    do_start(32'h0000_0203);
    send_word(4'h8, 4'h0, 4'h5, 4'h0, 4'h0, 16'h1234, 1'b0);
    send_word(4'h6, 4'h1, 4'h9, 4'h4, 4'h6, 16'hFFFF, 1'b0);
    send_word(4'h5, 4'h3, 4'h0, 4'h2, 4'h7, 16'h0008, 1'b1);
    wait_done();
    compare_session("three_word");
    if (obs_q.size() == 3) begin
      check("three_word_w2", obs_q[2], {32'h208, 32'h50270008});
    end

    // --- back-pressure: 4 accepted, then in_ready low and head held
    imem_wr_ready = 1'b0;
    do_start(32'h400);
    for (int i = 0; i < 4; i++) begin
      send_word(4'h0, 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3), 16'h0, 1'b0);
    end
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_wr_en", imem_wr_en, 1'b1);
    check("bp_head_data", imem_wr_data, exp_q[0][31:0]);
    check("bp_head_addr", imem_addr, 32'h400);
    @(posedge clk);
    #1;
    // start while running must be ignored
    base_addr = 32'h5000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready_still_low", in_ready, 1'b0);
    check("bp_addr_after_ignored_start", imem_addr, 32'h400);
    imem_wr_ready = 1'b1;
    send_word(4'h8, 4'h2, 4'h3, 4'h4, 4'h0, 16'h5555, 1'b0);
    send_word(4'hA, 4'h6, 4'h7, 4'h8, 4'h0, 16'hAAAA, 1'b1);
    wait_done();
    compare_session("backpressure");
    check("bp_inst_count_six", inst_count, 16'd6);

    // --- illegal class between two legal words
    do_start(32'h600);
    send_word(4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0);
    send_word(4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 16'h1111, 1'b0);
    send_word(4'h9, 4'h0, 4'h6, 4'h7, 4'h0, 16'h0040, 1'b1);
    wait_done();
    compare_session("illegal_mid");
    check("illegal_mid_err", err_illegal, 1'b1);

    // next start clears the sticky error; final illegal with empty FIFO
    do_start(32'h700);
    check("err_cleared_on_start", err_illegal, 1'b0);
    send_word(4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 16'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    send_word(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b1);
    @(negedge clk);
    check("illegal_last_done_next_cycle", done, 1'b1);
    @(negedge clk);
    check("illegal_last_done_pulse", done, 1'b0);
    check("illegal_last_busy", busy, 1'b0);
    compare_session("illegal_last");
    @(posedge clk);
    #1;

    // --- address wrap
    do_start(32'hFFFF_FFFC);
    send_word(4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 16'h0, 1'b0);
    send_word(4'hB, 4'h0, 4'h2, 4'h3, 4'h0, 16'h0100, 1'b1);
    wait_done();
    compare_session("wrap");
    if (obs_q.size() == 2) check("wrap_second_addr", obs_q[1][63:32], 32'h0);

    // --- reset in mid-session with 3 words buffered
    imem_wr_ready = 1'b0;
    do_start(32'h800);
    for (int i = 0; i < 3; i++) begin
      send_word(4'h8, 4'(i), 4'h1, 4'h2, 4'h0, 16'(i), 1'b0);
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    imem_wr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_no_writes", 64'(obs_q.size()), 64'd0);
    check("post_reset_wr_en", imem_wr_en, 1'b0);
    check("post_reset_busy", busy, 1'b0);
    do_start(32'h900);
    send_word(4'h0, 4'h7, 4'h3, 4'h1, 4'h2, 16'h0, 1'b1);
    wait_done();
    compare_session("after_reset");

    // --- randomized sessions with random back-pressure
    rand_ready = 1'b1;
    for (int s = 0; s < 25; s++) begin
      int n;
      n = $urandom_range(1, 8);
      do_start($urandom);
      for (int w = 0; w < n; w++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_word(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 16'($urandom), (w == n - 1) ? 1'b1 : 1'b0);
      end
      wait_done();
      compare_session("random");
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
- Instruction encoder/loader: the write-side counterpart of the instruction decoder. Accepts instruction fields (primary class, function, register numbers, immediate) over a valid/ready handshake. Packs them into 32-bit instruction words in the exact formats the decoder consumes.
- Buffers encoded words in a small FIFO and writes them to instruction memory at consecutive word addresses starting from a programmed base.
- Used by the boot/test path to load programs without a precompiled memory image.

Parameters:
- INST_BIT_WIDTH, 32, instruction word width.
- ADDR_BIT_WIDTH, 32, instruction memory byte-address width.
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a load session; sampled only in IDLE
- base_addr  input  ADDR_BIT_WIDTH  first write byte address; bits [1:0] forced to 0
- in_valid  input  1  field set valid
- in_ready  output  1  encoder can accept a field set
- in_class  input  4  primary opcode, becomes inst[31:28]
- in_fn  input  4  function/secondary opcode
- in_rd  input  4  destination register
- in_rs1  input  4  source register 1
- in_rs2  input  4  source register 2
- in_imm  input  16  immediate
- in_last  input  1  marks final instruction of session
- imem_wr_en  output  1  write request
- imem_wr_ready  input  1  memory accepts write this cycle
- imem_addr  output  ADDR_BIT_WIDTH  write byte address
- imem_wr_data  output  INST_BIT_WIDTH  encoded word
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when session completes
- err_illegal  output  1  sticky: an unsupported class was received
- inst_count  output  16  words written this session

Behaviour:
- Reset (async, any state): state IDLE; FIFO emptied; in_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0, busy=0, done=0, err_illegal=0, inst_count=0.
- States: IDLE -> RUN on start. RUN -> DONE when last seen and FIFO empty. DONE -> IDLE after one cycle with done=1. start outside IDLE is ignored.
- On start: addr<=base_addr with [1:0]=0; inst_count<=0; err_illegal<=0; last_seen<=0.
- Accept rule (RUN only): in_ready = !fifo_full && !last_seen. Transfer when in_valid && in_ready. in_last on a transfer sets last_seen.
- Full rule: a pop in the same cycle does not open space for that cycle's push; in_ready is based on registered fullness only.
- Encoding per in_class (unlisted bits are 0):
  - 0000 ALU, 0010 CMP: {class, fn, rd, rs1, rs2, 12'h000}
  - 1000 ALUI, 1010 CMPI: {class, fn, rd, rs1, imm}
  - 0110 BR: {class, fn, rs1, rs2, imm}; in_rd ignored
  - 1001 LW, 1011 JAL: {class, 4'h0, rd, rs1, imm}; in_fn ignored
  - 0101 SW: {class, 4'h0, rs1, rs2, imm}
  - any other class: consumed; err_illegal<=1; nothing pushed; in_last still honoured.
- Encode is registered into the FIFO. An accepted word is visible on imem_wr_data no earlier than the next cycle. There is no combinational path from in_* to imem_*.
- Write side: imem_wr_en = FIFO non-empty (in RUN). imem_wr_data = FIFO head. imem_addr = addr register.
  - A write completes on imem_wr_en && imem_wr_ready: pop; addr += 4; inst_count += 1.
  - imem_wr_data and imem_addr are held stable while imem_wr_en=1 and imem_wr_ready=0.
- Wrap: addr wraps modulo 2^ADDR_BIT_WIDTH; inst_count wraps at 16 bits.
- Illegal final instruction with empty FIFO: DONE is entered on the next cycle.
- Outputs outside RUN: in_ready=0 and imem_wr_en=0. imem_addr and inst_count hold their last values until the next start.

Test Plan:
- start base_addr=0x100; send ALU class=0000 fn=0111 rd=3 rs1=1 rs2=2 last=1, wr_ready=1 -> one write at 0x100 with data 0x07312000; done pulses; inst_count=1; busy returns 0.
- Send ALUI (8,0,rd5,rs1 0,imm 0x1234), then BR (6, fn1, rs1 4, rs2 6, rd 9, imm 0xFFFF), then SW (5, fn3, rs1 2, rs2 7, imm 0x0008, last) -> 0x80501234 @base, 0x6146FFFF @base+4, 0x50270008 @base+8.
- Hold wr_ready=0 and offer 6 words -> in_ready drops after 4 accepted and imem_wr_data stays stable. Release -> all 6 written in order at consecutive +4 addresses; inst_count=6.
- Send class=0001 between two legal words -> err_illegal=1; only 2 writes, at base and base+4; err_illegal clears on the next start.
- base_addr=0xFFFFFFFC, 2 words -> writes at 0xFFFFFFFC then 0x00000000.
- Assert reset mid-session with 3 words buffered -> all outputs at reset values immediately; no further writes; a new start works normally.
